// File: rtl/wake_port_arbiter_pkg.sv
// Shared wake-port types: broadcast payload, tag width constants, completion source ids.
package wake_port_arbiter_pkg;

  localparam int NUM_PHY_REG   = 64;
  localparam int PHY_W         = 6;
  localparam int NUM_WAKE_PORT = 2;

  typedef struct packed {
    logic             Valid;
    logic [PHY_W-1:0] Phydst;
  } Wake_Up_port;

  typedef enum logic [1:0] {
    WAKE_SRC_ALU0 = 2'd0,
    WAKE_SRC_ALU1 = 2'd1,
    WAKE_SRC_MUL  = 2'd2,
    WAKE_SRC_LSU  = 2'd3
  } wake_src_e;

endpackage

// File: rtl/wake_src_fifo.sv
// Per-source in-order tag queue with circular pointers and an occupancy count.
// Push is accepted in the cycle after the head is popped at the earliest; ready follows the registered count.
module wake_src_fifo #(
  parameter  int DEPTH = 2,
  parameter  int W     = 6,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [W-1:0]     push_dat,
  input  logic             pop,
  output logic [W-1:0]     head_dat,
  output logic [CNT_W-1:0] count,
  output logic             ready
);

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]        wr_q, wr_d;
  logic [PTR_W-1:0]        rd_q, rd_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = push_dat;
        wr_d        = ptr_inc(wr_q);
      end
      if (pop) begin
        rd_d = ptr_inc(rd_q);
      end
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_dat = mem_q[rd_q];
  assign count    = cnt_q;
  assign ready    = (cnt_q < CNT_W'(DEPTH));

endmodule

// File: rtl/wake_port_arbiter.sv
// Round-robin sharing of the two wake broadcast ports among ALU0/ALU1/MUL/LSU tag queues.
// Ports are registered (tag visible one edge after acceptance); per-source Req_Ready drops when its queue is full.
module wake_port_arbiter
  import wake_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = int'(WAKE_SRC_LSU) + 1,
  parameter int NUM_PORT = NUM_WAKE_PORT,
  parameter int DEPTH    = 2,
  parameter int PHY_W    = wake_port_arbiter_pkg::PHY_W
) (
  input  logic                            Clk,
  input  logic                            Rst_n,
  input  logic                            Flush,
  input  logic [NUM_REQ-1:0]              Req_Valid,
  input  logic [NUM_REQ-1:0][PHY_W-1:0]   Req_Phydst,
  output logic [NUM_REQ-1:0]              Req_Ready,
  output Wake_Up_port                     Port1,
  output Wake_Up_port                     Port2,
  output logic                            Pending
);

  localparam int REQ_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [NUM_REQ-1:0]             push;
  logic [NUM_REQ-1:0]             pop;
  logic [NUM_REQ-1:0]             nonempty;
  logic [NUM_REQ-1:0][PHY_W-1:0]  head;
  logic [CNT_W-1:0]               cnt [NUM_REQ];

  logic [NUM_PORT-1:0]            gnt_vld;
  logic [NUM_PORT-1:0][REQ_W-1:0] gnt_idx;
  logic [REQ_W-1:0]               scan_idx;
  logic                           scan_taken;
  logic [REQ_W-1:0]               last_idx;
  logic                           any_gnt;

  logic [REQ_W-1:0]               rr_q, rr_d;
  Wake_Up_port [NUM_PORT-1:0]     port_q, port_d;

  // Tag 0 is permanently ready downstream, so it completes the handshake without occupying a slot.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_src
    assign push[i] = Req_Valid[i] & Req_Ready[i] & (Req_Phydst[i] != '0) & ~Flush;

    wake_src_fifo #(
      .DEPTH (DEPTH),
      .W     (PHY_W)
    ) u_fifo (
      .clk      (Clk),
      .rst_n    (Rst_n),
      .flush    (Flush),
      .push     (push[i]),
      .push_dat (Req_Phydst[i]),
      .pop      (pop[i]),
      .head_dat (head[i]),
      .count    (cnt[i]),
      .ready    (Req_Ready[i])
    );

    assign nonempty[i] = (cnt[i] != '0);
  end

  // Walk the sources circularly from rr; each non-empty source takes the next free port.
  always_comb begin
    gnt_vld    = '0;
    gnt_idx    = '0;
    scan_idx   = '0;
    scan_taken = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx   = REQ_W'((int'(rr_q) + k) % NUM_REQ);
      scan_taken = 1'b0;
      for (int p = 0; p < NUM_PORT; p++) begin
        if (!scan_taken && !gnt_vld[p] && nonempty[scan_idx]) begin
          gnt_vld[p] = 1'b1;
          gnt_idx[p] = scan_idx;
          scan_taken = 1'b1;
        end
      end
    end
  end

  always_comb begin
    pop      = '0;
    any_gnt  = 1'b0;
    last_idx = '0;
    port_d   = '0;
    for (int p = 0; p < NUM_PORT; p++) begin
      if (gnt_vld[p]) begin
        pop[gnt_idx[p]]  = 1'b1;
        any_gnt          = 1'b1;
        last_idx         = gnt_idx[p];
        port_d[p].Valid  = 1'b1;
        port_d[p].Phydst = head[gnt_idx[p]];
      end
    end
    rr_d = rr_q;
    if (any_gnt) begin
      rr_d = (last_idx == REQ_W'(NUM_REQ - 1)) ? '0 : last_idx + 1'b1;
    end
    if (Flush) begin
      rr_d   = '0;
      port_d = '0;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rr_q   <= '0;
      port_q <= '0;
    end else begin
      rr_q   <= rr_d;
      port_q <= port_d;
    end
  end

  assign Port1   = port_q[0];
  assign Port2   = port_q[1];
  assign Pending = |nonempty;

endmodule

// File: tb/tb_wake_port_arbiter.sv
// Bench for wake_port_arbiter: directed vector table, hand sequences, and randomized traffic vs a queue model.
module tb_wake_port_arbiter;
  import wake_port_arbiter_pkg::*;

  localparam int NQ = 4;
  localparam int QD = 2;

  logic                 Clk;
  logic                 Rst_n;
  logic                 flush;
  logic [NQ-1:0]        req_vld;
  logic [NQ-1:0][5:0]   req_tag;
  logic [NQ-1:0]        Req_Ready;
  Wake_Up_port          Port1, Port2;
  logic                 Pending;

  wake_port_arbiter dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .Flush      (flush),
    .Req_Valid  (req_vld),
    .Req_Phydst (req_tag),
    .Req_Ready  (Req_Ready),
    .Port1      (Port1),
    .Port2      (Port2),
    .Pending    (Pending)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference: one queue of tags per source plus the rotating start position.
  int         mq [NQ][$];
  int         mrr;
  logic [6:0] mp1, mp2;
  logic [3:0] m_acc;

  typedef struct {
    logic       flush;
    logic [3:0] vld;
    logic [5:0] t0, t1, t2, t3;
    logic [6:0] p1, p2;
    logic [3:0] rdy;
    logic       pend;
  } vec_t;

  vec_t vec [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_ready();
    logic [3:0] r;
    for (int i = 0; i < NQ; i++) r[i] = (mq[i].size() < QD);
    return r;
  endfunction

  function automatic logic m_pend();
    logic pe = 1'b0;
    for (int i = 0; i < NQ; i++) if (mq[i].size() != 0) pe = 1'b1;
    return pe;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NQ; i++) mq[i].delete();
    mrr = 0;
    mp1 = '0;
    mp2 = '0;
  endtask

  task automatic model_edge();
    int g [2];
    int n;
    int idx;
    for (int i = 0; i < NQ; i++) m_acc[i] = req_vld[i] && (mq[i].size() < QD);
    if (flush) begin
      model_reset();
    end else begin
      n = 0;
      g[0] = -1;
      g[1] = -1;
      for (int k = 0; k < NQ; k++) begin
        idx = (mrr + k) % NQ;
        if (mq[idx].size() != 0 && n < 2) begin
          g[n] = idx;
          n++;
        end
      end
      mp1 = (n > 0) ? {1'b1, 6'(mq[g[0]][0])} : 7'd0;
      mp2 = (n > 1) ? {1'b1, 6'(mq[g[1]][0])} : 7'd0;
      for (int j = 0; j < n; j++) void'(mq[g[j]].pop_front());
      if (n > 0) mrr = (g[n-1] + 1) % NQ;
      for (int i = 0; i < NQ; i++)
        if (m_acc[i] && req_tag[i] != 6'd0) mq[i].push_back(int'(req_tag[i]));
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    model_edge();
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".port1"},   {25'd0, Port1}, {25'd0, mp1});
    chk({tag, ".port2"},   {25'd0, Port2}, {25'd0, mp2});
    chk({tag, ".ready"},   {28'd0, Req_Ready}, {28'd0, m_ready()});
    chk({tag, ".pending"}, {31'd0, Pending}, {31'd0, m_pend()});
  endtask

  task automatic idle_inputs();
    flush   = 1'b0;
    req_vld = '0;
    req_tag = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int         mul_seen [$];
    int         guard;
    logic [3:0] has_req;
    logic [5:0] pend_tag [NQ];

    // Directed vectors; expectations hand-derived from the round-robin rules.
    vec[0]  = '{1'b0, 4'b1111, 6'd5, 6'd9, 6'd17, 6'd33, 7'd0, 7'd0, 4'b1111, 1'b1};
    vec[1]  = '{1'b0, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0, {1'b1, 6'd5}, {1'b1, 6'd9}, 4'b1111, 1'b1};
    vec[2]  = '{1'b0, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0, {1'b1, 6'd17}, {1'b1, 6'd33}, 4'b1111, 1'b0};
    vec[3]  = '{1'b0, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0, 7'd0, 7'd0, 4'b1111, 1'b0};
    vec[4]  = '{1'b0, 4'b0001, 6'd12, 6'd0, 6'd0, 6'd0, 7'd0, 7'd0, 4'b1111, 1'b1};
    vec[5]  = '{1'b0, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0, {1'b1, 6'd12}, 7'd0, 4'b1111, 1'b0};
    vec[6]  = '{1'b0, 4'b1000, 6'd0, 6'd0, 6'd0, 6'd0, 7'd0, 7'd0, 4'b1111, 1'b0};
    vec[7]  = '{1'b0, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0, 7'd0, 7'd0, 4'b1111, 1'b0};
    vec[8]  = '{1'b0, 4'b1101, 6'd7, 6'd0, 6'd8, 6'd11, 7'd0, 7'd0, 4'b1111, 1'b1};
    vec[9]  = '{1'b1, 4'b0010, 6'd0, 6'd40, 6'd0, 6'd0, 7'd0, 7'd0, 4'b1111, 1'b0};
    vec[10] = '{1'b0, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0, 7'd0, 7'd0, 4'b1111, 1'b0};
    vec[11] = '{1'b0, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0, 7'd0, 7'd0, 4'b1111, 1'b0};

    idle_inputs();
    Rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    chk("rst.port1", {25'd0, Port1}, 32'd0);
    chk("rst.port2", {25'd0, Port2}, 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    #1;
    chk("rst.ready", {28'd0, Req_Ready}, 32'hF);
    chk("rst.pending", {31'd0, Pending}, 32'd0);

    // Reset asserted asynchronously while queues hold tags and the ports are live.
    req_vld = 4'b1111;
    req_tag = {6'd4, 6'd3, 6'd2, 6'd1};
    tick();
    chk_model("mid_rst.load");
    idle_inputs();
    tick();
    chk_model("mid_rst.live");
    chk("mid_rst.live_valid", {31'd0, Port1.Valid}, 32'd1);
    #2;
    Rst_n = 1'b0;
    #1;
    chk("mid_rst.async_port1", {25'd0, Port1}, 32'd0);
    chk("mid_rst.async_port2", {25'd0, Port2}, 32'd0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    model_reset();
    #1;
    chk("mid_rst.ready", {28'd0, Req_Ready}, 32'hF);
    chk("mid_rst.pending", {31'd0, Pending}, 32'd0);

    for (int v = 0; v < 12; v++) begin
      flush   = vec[v].flush;
      req_vld = vec[v].vld;
      req_tag = {vec[v].t3, vec[v].t2, vec[v].t1, vec[v].t0};
      tick();
      chk($sformatf("vec%0d.port1", v), {25'd0, Port1}, {25'd0, vec[v].p1});
      chk($sformatf("vec%0d.port2", v), {25'd0, Port2}, {25'd0, vec[v].p2});
      chk($sformatf("vec%0d.ready", v), {28'd0, Req_Ready}, {28'd0, vec[v].rdy});
      chk($sformatf("vec%0d.pending", v), {31'd0, Pending}, {31'd0, vec[v].pend});
    end
    idle_inputs();

    // MUL fills its queue behind ALU traffic; the third tag must be held, not dropped.
    req_vld = 4'b0111;
    req_tag = {6'd0, 6'd20, 6'd2, 6'd1};
    tick();
    chk_model("bp.a");
    req_tag = {6'd0, 6'd21, 6'd4, 6'd3};
    tick();
    chk_model("bp.b");
    chk("bp.mul_full", {31'd0, Req_Ready[2]}, 32'd0);
    req_tag = {6'd0, 6'd22, 6'd6, 6'd5};
    guard = 0;
    do begin
      tick();
      chk_model("bp.hold");
      if (Port1.Valid && Port1.Phydst >= 6'd20 && Port1.Phydst <= 6'd22) mul_seen.push_back(int'(Port1.Phydst));
      if (Port2.Valid && Port2.Phydst >= 6'd20 && Port2.Phydst <= 6'd22) mul_seen.push_back(int'(Port2.Phydst));
      req_vld[1:0] = 2'b00;
      guard++;
    end while (!m_acc[2] && guard < 10);
    chk("bp.mul_accepted", {31'd0, m_acc[2]}, 32'd1);
    idle_inputs();
    for (int c = 0; c < 6; c++) begin
      tick();
      chk_model("bp.drain");
      if (Port1.Valid && Port1.Phydst >= 6'd20 && Port1.Phydst <= 6'd22) mul_seen.push_back(int'(Port1.Phydst));
      if (Port2.Valid && Port2.Phydst >= 6'd20 && Port2.Phydst <= 6'd22) mul_seen.push_back(int'(Port2.Phydst));
    end
    chk("bp.mul_count", mul_seen.size(), 32'd3);
    for (int j = 0; j < 3; j++)
      chk($sformatf("bp.mul_order%0d", j), (j < mul_seen.size()) ? mul_seen[j] : -1, 20 + j);

    // Random traffic: sources hold each request until the model says it was accepted.
    has_req = '0;
    for (int i = 0; i < NQ; i++) pend_tag[i] = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NQ; i++) begin
        if (!has_req[i] && ($urandom_range(0, 2) != 0)) begin
          has_req[i]  = 1'b1;
          pend_tag[i] = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
        end
        req_vld[i] = has_req[i];
        req_tag[i] = pend_tag[i];
      end
      flush = ($urandom_range(0, 31) == 0);
      tick();
      chk_model("rand");
      for (int i = 0; i < NQ; i++) if (m_acc[i]) has_req[i] = 1'b0;
    end
    idle_inputs();
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_model("rand.drain");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
